ap_si_wall_pipe: RTL
====================

AP_SI_WALL_PIPE -- requirements
Module: ap_si_wall_pipe

Interface
REQ-001 Parameter DW, default 12: operand width in bits, signed two's complement; legal range 4..32.
REQ-002 Parameter APX_R, default 10: number of low product columns removed in approximate mode; legal range 0..2*DW-1.
REQ-003 Parameter TW, default 4: width of the user tag carried alongside each operand pair.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset, sampled on the rising clk edge.
REQ-006 in_valid  in  1  operand pair present.
REQ-007 in_ready  out  1  block accepts operand pair this cycle.
REQ-008 muld  in  DW  signed multiplicand.
REQ-009 mulr  in  DW  signed multiplier.
REQ-010 in_apx  in  1  1 = approximate (truncated) mode for this pair, 0 = exact.
REQ-011 in_tag  in  TW  user tag; returned unchanged with the result.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 res  out  2*DW  signed product.
REQ-015 out_tag  out  TW  tag of the transaction currently on res.
REQ-016 apx_cnt  out  16  count of approximate transactions delivered.

Function
REQ-017 Pipeline SHALL have three register stages: S1 Baugh-Wooley partial-product matrix, S2 Wallace compression to two rows, S3 final carry-propagate add plus output register.
REQ-018 Handshake: a transfer occurs on a cycle with in_valid=1 and in_ready=1; a delivery occurs on a cycle with out_valid=1 and out_ready=1.
REQ-019 Global advance enable adv = !(out_valid && !out_ready); all stage registers load only when adv=1; in_ready = adv.
REQ-020 Each stage SHALL hold a valid bit; bubbles propagate; with adv held at 1, latency is exactly 3 cycles from transfer to out_valid.
REQ-021 Throughput SHALL be one transaction per cycle while out_ready=1; no transaction is dropped or duplicated under any out_ready pattern.
REQ-022 While out_valid=1 and out_ready=0, res, out_tag and out_valid SHALL remain stable.
REQ-023 Exact mode: res SHALL equal muld*mulr as a full 2*DW-bit signed product for all inputs, including -2^(DW-1) * -2^(DW-1).
REQ-024 Approximate mode: every Baugh-Wooley matrix bit, sign-inversion bit and correction constant in a column below APX_R SHALL be discarded before compression; res[APX_R-1:0]=0; res[2*DW-1:APX_R] SHALL equal the wrapped (mod 2^(2*DW)) sum of the remaining matrix bits, with no carry-in from the discarded columns.
REQ-025 APX_R=0 SHALL make approximate mode identical to exact mode.
REQ-026 The in_apx and in_tag values SHALL travel with their operands through every stage; the mode is selected per transaction, so mixed-mode back-to-back streams are legal.
REQ-027 apx_cnt SHALL increment by 1 on each delivery whose transaction was approximate, and wrap from 0xFFFF to 0.
REQ-028 Stage valid bits SHALL update only when adv=1; data registers may load unconditionally when the stage valid is 0.

Reset
REQ-029 While rst_n=0 at a clock edge, all stage valid bits SHALL clear, out_valid=0, res=0, out_tag=0 and apx_cnt=0.
REQ-030 While rst_n=0, in_ready SHALL read 1, but no transfer is captured.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight transactions; the first transfer after release SHALL appear after exactly 3 cycles.

Verification
REQ-032 DW=12, APX_R=10, exact mode, out_ready=1: pairs (-2048,-2048), (2047,-2048), (-1,-1), tags 1,2,3 -> res 4194304, -4192256, 1 with tags 1,2,3, each 3 cycles after its transfer.
REQ-033 Approximate mode on the same pairs -> res low 10 bits = 0, and values match the column-truncated Baugh-Wooley bit-level model; apx_cnt=3 after the third delivery.
REQ-034 Back-pressure: stream 8 random pairs with out_ready toggled pseudo-randomly -> all 8 results are delivered in order, none lost or duplicated, and res is stable while stalled.
REQ-035 Mixed mode: alternating in_apx 0/1 on identical operands 1234*-567 -> exact res -699678 alternates with its truncated model value; apx_cnt counts only approximate deliveries.
REQ-036 Reset at cycle 2 of a 3-deep in-flight burst -> out_valid stays 0 and apx_cnt=0; a new pair after release yields its result exactly 3 cycles later.
REQ-037 Random regression at DW=8, APX_R=0 and at DW=16, APX_R=12 -> exact results match the signed product; approximate results match the bit-level model.

Source files
------------

// File: rtl/ap_si_wall_pipe_if.sv
// Operand/result handshake bundle for ap_si_wall_pipe.
interface ap_si_wall_pipe_if #(
    parameter int DW = 12,
    parameter int TW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   muld;
    logic [DW-1:0]   mulr;
    logic            in_apx;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] res;
    logic [TW-1:0]   out_tag;
    logic [15:0]     apx_cnt;

    modport master (
        output in_valid, muld, mulr, in_apx, in_tag, out_ready,
        input  in_ready, out_valid, res, out_tag, apx_cnt
    );

    modport slave (
        input  in_valid, muld, mulr, in_apx, in_tag, out_ready,
        output in_ready, out_valid, res, out_tag, apx_cnt
    );
endinterface

// File: rtl/ap_si_wall_pipe.sv
// Three-stage signed Baugh-Wooley / Wallace multiplier with optional
// per-transaction column truncation, tag passthrough and a delivered
// approximate-transaction counter.
module ap_si_wall_pipe #(
    parameter int DW    = 12,
    parameter int APX_R = 10,
    parameter int TW    = 4
) (
    input logic              clk,
    input logic              rst_n,
    ap_si_wall_pipe_if.slave bus
);
    localparam int unsigned PW  = 2 * DW;
    localparam int unsigned NR  = DW + 1;
    localparam int unsigned UDW = DW;
    localparam int unsigned UR  = APX_R;

    logic          w_adv;
    logic          w_bit;
    logic [PW-1:0] w_pp   [NR];
    logic [PW-1:0] w_tree [NR];
    logic [PW-1:0] w_nxt  [NR];
    int unsigned   w_cnt;
    int unsigned   w_ncnt;

    logic [PW-1:0] r_s1_pp [NR];
    logic          r_s1_v;
    logic          r_s1_apx;
    logic [TW-1:0] r_s1_tag;

    logic [PW-1:0] r_s2_sum;
    logic [PW-1:0] r_s2_car;
    logic          r_s2_v;
    logic          r_s2_apx;
    logic [TW-1:0] r_s2_tag;

    logic [PW-1:0] r_s3_res;
    logic          r_s3_v;
    logic          r_s3_apx;
    logic [TW-1:0] r_s3_tag;
    logic [15:0]   r_apx_cnt;

    // Whole pipe advances unless the output holds an undelivered result.
    always_comb begin
        w_adv = !(r_s3_v && !bus.out_ready);
    end

    assign bus.in_ready  = w_adv | !rst_n;
    assign bus.out_valid = r_s3_v;
    assign bus.res       = r_s3_res;
    assign bus.out_tag   = r_s3_tag;
    assign bus.apx_cnt   = r_apx_cnt;

    // Baugh-Wooley matrix: row j holds muld*mulr[j]; cross sign terms are
    // inverted and the 2^DW + 2^(2DW-1) correction sits in the last row.
    // In approximate mode every bit in a column below APX_R is dropped here.
    always_comb begin
        w_bit = 1'b0;
        for (int unsigned j = 0; j < NR; j++) begin
            w_pp[j] = '0;
        end
        for (int unsigned j = 0; j < UDW; j++) begin
            for (int unsigned i = 0; i < UDW; i++) begin
                w_bit = bus.muld[i] & bus.mulr[j];
                if ((i == UDW - 1) != (j == UDW - 1)) begin
                    w_bit = ~w_bit;
                end
                if (!(bus.in_apx && ((i + j) < UR))) begin
                    w_pp[j][i+j] = w_bit;
                end
            end
        end
        if (!(bus.in_apx && (UDW < UR))) begin
            w_pp[NR-1][UDW] = 1'b1;
        end
        if (!(bus.in_apx && ((PW - 1) < UR))) begin
            w_pp[NR-1][PW-1] = 1'b1;
        end
    end

    // S1 valid: cleared by reset, otherwise follows in_valid on advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v <= 1'b0;
        end else if (w_adv) begin
            r_s1_v <= bus.in_valid;
        end
    end

    // S1 data: partial-product matrix with its mode and tag.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_pp  <= w_pp;
            r_s1_apx <= bus.in_apx;
            r_s1_tag <= bus.in_tag;
        end
    end

    // Wallace reduction: each level compresses disjoint row triples with
    // full adders; carries shift left and wrap mod 2^(2DW). Carries only move
    // upward, so truncated columns stay empty.
    always_comb begin
        for (int unsigned k = 0; k < NR; k++) begin
            w_tree[k] = r_s1_pp[k];
            w_nxt[k]  = '0;
        end
        w_cnt  = NR;
        w_ncnt = 0;
        for (int unsigned lv = 0; lv < NR; lv++) begin
            if (w_cnt > 2) begin
                for (int unsigned k = 0; k < NR; k++) begin
                    w_nxt[k] = '0;
                end
                w_ncnt = 0;
                for (int unsigned k = 0; k < NR; k += 3) begin
                    if (k + 2 < w_cnt) begin
                        w_nxt[w_ncnt]     = w_tree[k] ^ w_tree[k+1] ^ w_tree[k+2];
                        w_nxt[w_ncnt + 1] = ((w_tree[k] & w_tree[k+1]) |
                                             (w_tree[k] & w_tree[k+2]) |
                                             (w_tree[k+1] & w_tree[k+2])) << 1;
                        w_ncnt = w_ncnt + 2;
                    end else if (k < w_cnt) begin
                        w_nxt[w_ncnt] = w_tree[k];
                        w_ncnt = w_ncnt + 1;
                        if (k + 1 < w_cnt) begin
                            w_nxt[w_ncnt] = w_tree[k+1];
                            w_ncnt = w_ncnt + 1;
                        end
                    end
                end
                for (int unsigned k = 0; k < NR; k++) begin
                    w_tree[k] = w_nxt[k];
                end
                w_cnt = w_ncnt;
            end
        end
    end

    // S2 valid: bubbles propagate on advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_v <= 1'b0;
        end else if (w_adv) begin
            r_s2_v <= r_s1_v;
        end
    end

    // S2 data: two compressed rows with mode and tag.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s2_sum <= w_tree[0];
            r_s2_car <= w_tree[1];
            r_s2_apx <= r_s1_apx;
            r_s2_tag <= r_s1_tag;
        end
    end

    // S3 output register: final carry-propagate add, held while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3_v   <= 1'b0;
            r_s3_res <= '0;
            r_s3_tag <= '0;
            r_s3_apx <= 1'b0;
        end else if (w_adv) begin
            r_s3_v   <= r_s2_v;
            r_s3_res <= r_s2_sum + r_s2_car;
            r_s3_tag <= r_s2_tag;
            r_s3_apx <= r_s2_apx;
        end
    end

    // Count approximate results as they are delivered; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_apx_cnt <= '0;
        end else if (r_s3_v && bus.out_ready && r_s3_apx) begin
            r_apx_cnt <= r_apx_cnt + 16'd1;
        end
    end
endmodule
